// File: rtl/opb_reg_pkg.sv
// opb_reg_pkg: shared OPB register-bank types, constants and byte-enable helper
package opb_reg_pkg;
    typedef enum logic [1:0] {IDLE, ACK, HOLD} opb_state_e;
    localparam int OPB_WORD_BYTES = 4;
    function automatic logic [31:0] opb_be_to_mask(input logic [0:3] be);
        return {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
    endfunction
endpackage

// File: rtl/opb_slave_ack_fsm.sv
// opb_slave_ack_fsm: address decode, one-shot ack state machine and read-data register
// ports: clk/rst_n clock and sync active-low reset; abus/select/rnw from the OPB master;
//        rd_word current read word from the bank; idx/idx_ok decoded register index;
//        acc one-cycle accept strobe; xfer_ack/rd_data slave response to the bus
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF,
    parameter int          C_N_REGS   = 4,
    parameter int          IW         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   abus,
    input  logic          select,
    input  logic          rnw,
    input  logic [31:0]   rd_word,
    output logic [IW-1:0] idx,
    output logic          idx_ok,
    output logic          acc,
    output logic          xfer_ack,
    output logic [31:0]   rd_data
);
    opb_state_e  state, nxt;
    logic [31:0] offset, word;
    logic        hit;
    // unsigned wrap makes addresses below the base land far above the window size
    assign offset   = abus - C_BASEADDR;
    assign hit      = select && offset <= C_HIGHADDR - C_BASEADDR;
    assign word     = offset / OPB_WORD_BYTES;
    assign idx      = word[IW-1:0];
    assign idx_ok   = word < C_N_REGS;
    assign xfer_ack = state == ACK;
    always_comb begin
        acc = state == IDLE && hit;
        nxt = state == IDLE ? (hit ? ACK : IDLE) : state == ACK ? HOLD : (select ? HOLD : IDLE);
    end
    // rd_data is only non-zero during ACK since it is reloaded with zero on every non-accept edge
    always_ff @(posedge clk) begin
        state   <= rst_n ? nxt : IDLE;
        rd_data <= rst_n && acc && rnw ? rd_word : '0;
    end
endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: N x 32-bit OPB register bank with RO, pulse and byte-enable writes
// ports: OPB_Clk/OPB_Rst_n clock and sync active-low reset; OPB_* master request;
//        Sl_* slave response (errAck/retry/toutSup tied low);
//        user_data_out/user_data_in register i at [32i+31:32i]; user_wr_stb per-register write pulse
module opb_register_bank_ppc2simulink
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_N_REGS     = 4,
    parameter logic [63:0] C_RO_MASK    = 64'd0,
    parameter logic [63:0] C_PULSE_MASK = 64'd0,
    parameter logic [31:0] C_INIT_VAL   = 32'h0
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [32*C_N_REGS-1:0]  user_data_out,
    input  logic [32*C_N_REGS-1:0]  user_data_in,
    output logic [C_N_REGS-1:0]     user_wr_stb
);
    localparam int IW = C_N_REGS > 1 ? $clog2(C_N_REGS) : 1;
    logic [31:0]         regs [C_N_REGS];
    logic [IW-1:0]       idx;
    logic                idx_ok, acc;
    logic [31:0]         rd_word, mask;
    logic [C_N_REGS-1:0] wr_sel;
    logic                unused_ok;
    assign unused_ok  = OPB_seqAddr;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign mask       = opb_be_to_mask(OPB_BE);
    assign rd_word    = !idx_ok ? '0 : C_RO_MASK[idx] ? user_data_in[{idx, 5'b0} +: 32] : regs[idx];
    opb_slave_ack_fsm #(
        .C_BASEADDR(C_BASEADDR),
        .C_HIGHADDR(C_HIGHADDR),
        .C_N_REGS  (C_N_REGS),
        .IW        (IW)
    ) u_fsm (
        .clk     (OPB_Clk),
        .rst_n   (OPB_Rst_n),
        .abus    (OPB_ABus),
        .select  (OPB_select),
        .rnw     (OPB_RNW),
        .rd_word (rd_word),
        .idx     (idx),
        .idx_ok  (idx_ok),
        .acc     (acc),
        .xfer_ack(Sl_xferAck),
        .rd_data (Sl_DBus)
    );
    for (genvar i = 0; i < C_N_REGS; i++) begin : g_reg
        assign wr_sel[i] = acc && !OPB_RNW && idx_ok && idx == IW'(i) && !C_RO_MASK[i];
        assign user_data_out[32*i +: 32] = regs[i];
    end
    // pulse registers clear on the edge that ends their strobe cycle
    always_ff @(posedge OPB_Clk) begin
        for (int i = 0; i < C_N_REGS; i++)
            regs[i] <= !OPB_Rst_n || C_RO_MASK[i] ? C_INIT_VAL
                     : wr_sel[i] ? (regs[i] & ~mask) | (OPB_DBus & mask)
                     : C_PULSE_MASK[i] && user_wr_stb[i] ? C_INIT_VAL : regs[i];
        user_wr_stb <= OPB_Rst_n ? wr_sel : '0;
    end
endmodule
